// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and default constants for the debouncer
package debounce_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam int DEF_STABLE_COUNT = 4;
    localparam int DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/debounce_sync_if.sv
// rtl/debounce_sync_if.sv - raw input and conditioned outputs of the debouncer
interface debounce_sync_if;

    logic d_in;
    logic q;
    logic rise;
    logic fall;

    modport master (output d_in, input q, input rise, input fall);
    modport slave  (input d_in, output q, output rise, output fall);

endinterface

// File: rtl/debounce_sync_sync2.sv
// rtl/debounce_sync_sync2.sv - two-flop synchroniser with a configurable reset level
module sync2 #(
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            s1 <= RESET_LEVEL;
            q  <= RESET_LEVEL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw input into a level plus edge pulses
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic            clock,
    input  logic            clear,
    debounce_sync_if.slave  bus
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    if (STABLE_COUNT < 1 || 64'(STABLE_COUNT) > CNT_MAX) begin : g_bad_stable_count
        $error("debounce_sync: STABLE_COUNT must be 1 .. 2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 s2;
    logic                 q_r, q_nxt;
    logic                 rise_r, rise_nxt;
    logic                 fall_r, fall_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 differ;
    logic                 take;
    state_t               state, state_nxt;

    sync2 #(.RESET_LEVEL(RESET_LEVEL)) u_sync2 (
        .clock (clock),
        .clear (clear),
        .d     (bus.d_in),
        .q     (s2)
    );

    assign differ   = (s2 != q_r);
    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            cnt    <= '0;
            q_r    <= RESET_LEVEL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q_r    <= q_nxt;
            rise_r <= rise_nxt;
            fall_r <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (differ && STABLE_COUNT != 1) state_nxt = SETTLING;
            SETTLING: if (!differ || cnt == LAST)      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A bounce back to q discards the run; only an unbroken run of STABLE_COUNT samples commits.
    always_comb begin
        cnt_nxt  = '0;
        take     = 1'b0;
        q_nxt    = q_r;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (differ) begin
                    if (STABLE_COUNT == 1) take = 1'b1;
                    else                   cnt_nxt = CNT_WIDTH'(1);
                end
            end
            SETTLING: begin
                if (differ) begin
                    if (cnt == LAST) take = 1'b1;
                    else             cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
        if (take) begin
            q_nxt    = s2;
            rise_nxt = s2;
            fall_nxt = !s2;
        end
    end

endmodule
